// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped data cache controller.
// Provides the FSM state enum, the byte-lane word type and pack/unpack helpers.
package cache_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WB,
      S_FILL,
      S_FLUSH_SCAN,
      S_FLUSH_WB,
      S_DONE
   } dcache_state_e;

   // byte [0] is the lowest address of the word
   typedef logic [0:3][7:0] word_t;

   function automatic logic [31:0] word_to_u32(input word_t w);
      return {w[3], w[2], w[1], w[0]};
   endfunction

   function automatic word_t u32_to_word(input logic [31:0] v);
      word_t w;
      w[0] = v[7:0];
      w[1] = v[15:8];
      w[2] = v[23:16];
      w[3] = v[31:24];
      return w;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: async read port, one sync write port.
// Ports: rd_* lookup, wr_en full-line write, clr_en dirty clear; rst_b clears valid/dirty.
module dcache_array
   import cache_pkg::*;
#(
   parameter int NUM_LINES = 256,
   parameter int TAG_BITS  = 22,
   localparam int IB       = $clog2(NUM_LINES)
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic [IB-1:0]       rd_idx,
   output logic                rd_valid,
   output logic                rd_dirty,
   output logic [TAG_BITS-1:0] rd_tag,
   output word_t               rd_data,
   input  logic                wr_en,
   input  logic                clr_en,
   input  logic [IB-1:0]       wr_idx,
   input  logic [TAG_BITS-1:0] wr_tag,
   input  word_t               wr_data,
   input  logic                wr_dirty
);

   logic [NUM_LINES-1:0] valid;
   logic [NUM_LINES-1:0] dirty;
   logic [TAG_BITS-1:0]  tags [NUM_LINES];
   word_t                data [NUM_LINES];

   assign rd_valid = valid[rd_idx];
   assign rd_dirty = dirty[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_data  = data[rd_idx];

   always_ff @(posedge clk) begin
      if (rst_b) begin
         valid <= '0;
         dirty <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
         dirty[wr_idx] <= wr_dirty;
      end else if (clr_en) begin
         dirty[wr_idx] <= 1'b0;
      end
   end

   // payload needs no reset: valid gates every use
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_idx] <= wr_tag;
         data[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller with halt flush.
// Ports: core_* access port, mem_* backing memory, halted/flush_done; DCACHE_PERF_EN adds counters.
module dcache_ctrl
   import cache_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NUM_LINES = 256
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            core_req,
   input  logic            core_we,
   input  logic [XLEN-1:0] core_addr,
   input  word_t           core_wdata,
   output word_t           core_rdata,
   output logic            core_ready,
   input  logic            halted,
   output logic            flush_done,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output word_t           mem_wdata,
   input  word_t           mem_rdata,
   input  logic            mem_ack
`ifdef DCACHE_PERF_EN
   ,
   output logic [31:0]     hit_count,
   output logic [31:0]     miss_count,
   output logic [31:0]     wb_count
`endif
);

   localparam int IB = $clog2(NUM_LINES);
   localparam int TB = XLEN - IB - 2;
   localparam logic [IB-1:0] LAST_IDX = IB'(NUM_LINES - 1);

   dcache_state_e state;

   logic [IB-1:0] miss_idx;
   logic [TB-1:0] miss_tag;
   logic          miss_we;
   word_t         miss_wdata;
   logic [IB-1:0] scan_idx;

   logic [IB-1:0] core_idx;
   logic [TB-1:0] core_tag;
   logic          unused_lsb;

   logic [IB-1:0] rd_idx;
   logic          rd_valid;
   logic          rd_dirty;
   logic [TB-1:0] rd_tag;
   word_t         rd_data;

   logic          wr_en;
   logic          clr_en;
   logic [IB-1:0] wr_idx;
   logic [TB-1:0] wr_tag;
   word_t         wr_data;
   logic          wr_dirty;

   logic access;
   logic hit;
   logic lookup_miss;
   logic victim_dirty;
   logic mem_done;

   assign core_idx   = core_addr[IB+1:2];
   assign core_tag   = core_addr[XLEN-1:IB+2];
   assign unused_lsb = ^core_addr[1:0];

   // halted wins over a same-cycle request
   assign access       = !rst_b && state == S_IDLE
                       && !halted && core_req;
   assign hit          = access && rd_valid
                       && rd_tag == core_tag;
   assign lookup_miss  = access && !hit;
   assign victim_dirty = rd_valid && rd_dirty;
   assign mem_done     = mem_req && mem_ack;

   assign core_ready = hit;
   assign core_rdata = hit ? rd_data : '0;

   always_comb begin
      rd_idx = core_idx;
      unique case (state)
         S_WB, S_FILL:             rd_idx = miss_idx;
         S_FLUSH_SCAN, S_FLUSH_WB: rd_idx = scan_idx;
         default:                  rd_idx = core_idx;
      endcase
   end

   always_comb begin
      wr_en    = 1'b0;
      clr_en   = 1'b0;
      wr_idx   = core_idx;
      wr_tag   = core_tag;
      wr_data  = core_wdata;
      wr_dirty = 1'b1;
      unique case (state)
         S_IDLE: begin
            // store hit, or store miss over a clean victim
            wr_en = access && core_we
                  && (hit || !victim_dirty);
         end
         S_WB: begin
            wr_idx  = miss_idx;
            wr_tag  = miss_tag;
            wr_data = miss_wdata;
            wr_en   = mem_done && miss_we;
            clr_en  = mem_done && !miss_we;
         end
         S_FILL: begin
            wr_idx   = miss_idx;
            wr_tag   = miss_tag;
            wr_data  = mem_rdata;
            wr_dirty = 1'b0;
            wr_en    = mem_done;
         end
         S_FLUSH_WB: begin
            wr_idx = scan_idx;
            clr_en = mem_done;
         end
         default: ;
      endcase
   end

   dcache_array #(
      .NUM_LINES (NUM_LINES),
      .TAG_BITS  (TB)
   ) u_array (
      .clk      (clk),
      .rst_b    (rst_b),
      .rd_idx   (rd_idx),
      .rd_valid (rd_valid),
      .rd_dirty (rd_dirty),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .clr_en   (clr_en),
      .wr_idx   (wr_idx),
      .wr_tag   (wr_tag),
      .wr_data  (wr_data),
      .wr_dirty (wr_dirty)
   );

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state      <= S_IDLE;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         flush_done <= 1'b0;
         scan_idx   <= '0;
         miss_idx   <= '0;
         miss_tag   <= '0;
         miss_we    <= 1'b0;
         miss_wdata <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (halted) begin
                  state    <= S_FLUSH_SCAN;
                  scan_idx <= '0;
               end else if (lookup_miss) begin
                  miss_idx   <= core_idx;
                  miss_tag   <= core_tag;
                  miss_we    <= core_we;
                  miss_wdata <= core_wdata;
                  if (victim_dirty) begin
                     state     <= S_WB;
                     mem_req   <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_addr  <= {rd_tag, core_idx, 2'b00};
                     mem_wdata <= rd_data;
                  end else if (!core_we) begin
                     state    <= S_FILL;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= {core_tag, core_idx, 2'b00};
                  end
               end
            end
            S_WB: begin
               if (mem_done) begin
                  mem_req <= 1'b0;
                  if (miss_we) begin
                     state <= S_IDLE;
                  end else begin
                     // fill request is raised one cycle later
                     state    <= S_FILL;
                     mem_we   <= 1'b0;
                     mem_addr <= {miss_tag, miss_idx, 2'b00};
                  end
               end
            end
            S_FILL: begin
               if (!mem_req) begin
                  mem_req <= 1'b1;
               end else if (mem_ack) begin
                  mem_req <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            S_FLUSH_SCAN: begin
               if (rd_dirty) begin
                  state     <= S_FLUSH_WB;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= {rd_tag, scan_idx, 2'b00};
                  mem_wdata <= rd_data;
               end else if (scan_idx == LAST_IDX) begin
                  state      <= S_DONE;
                  flush_done <= 1'b1;
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
            S_FLUSH_WB: begin
               if (mem_done) begin
                  mem_req <= 1'b0;
                  if (scan_idx == LAST_IDX) begin
                     state      <= S_DONE;
                     flush_done <= 1'b1;
                  end else begin
                     state    <= S_FLUSH_SCAN;
                     scan_idx <= scan_idx + 1'b1;
                  end
               end
            end
            S_DONE: begin
               flush_done <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DCACHE_PERF_EN
   logic wb_done;

   assign wb_done = mem_done
                  && (state == S_WB || state == S_FLUSH_WB);

   always_ff @(posedge clk) begin
      if (rst_b) begin
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (hit && hit_count != '1)
            hit_count <= hit_count + 32'd1;
         if (lookup_miss && miss_count != '1)
            miss_count <= miss_count + 32'd1;
         if (wb_done && wb_count != '1)
            wb_count <= wb_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed cases plus random traffic
// against an array-based cache/memory reference model.
module tb_dcache_ctrl;
   import cache_pkg::*;

   localparam int NL = 256;

   logic        clk;
   logic        rst_b;
   logic        core_req;
   logic        core_we;
   logic [31:0] core_addr;
   word_t       core_wdata;
   word_t       core_rdata;
   logic        core_ready;
   logic        halted;
   logic        flush_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   word_t       mem_wdata;
   word_t       mem_rdata;
   logic        mem_ack;
`ifdef DCACHE_PERF_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
   logic [31:0] wb_count;
`endif

   dcache_ctrl #(.XLEN(32), .NUM_LINES(NL)) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_rdata (core_rdata),
      .core_ready (core_ready),
      .halted     (halted),
      .flush_done (flush_done),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack)
`ifdef DCACHE_PERF_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count),
      .wb_count   (wb_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } tx_t;

   tx_t log_q[$];

   // reference: cache contents plus architectural memory view
   bit          rv   [NL];
   bit          rdy  [NL];
   logic [21:0] rt   [NL];
   logic [31:0] rdat [NL];
   logic [31:0] bmem [logic [31:0]];
   logic [31:0] arch [logic [31:0]];

   int total = 0;
   int bad   = 0;
   bit mem_hold  = 1'b0;
   bit force_ack = 1'b0;
   int lat       = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] bmem_rd(input logic [31:0] a);
      return bmem.exists(a) ? bmem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] a);
      return arch.exists(a) ? arch[a] : bmem_rd(a);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NL; i++) begin
         rv[i]  = 1'b0;
         rdy[i] = 1'b0;
      end
      arch.delete();
   endfunction

   // backing memory: random latency, one-cycle ack pulse
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (force_ack) begin
            mem_rdata = u32_to_word(32'hBADB_AD00);
            mem_ack   = 1'b1;
            force_ack = 1'b0;
         end else if (mem_req && !mem_hold) begin
            if (lat > 0) begin
               lat--;
            end else begin
               if (mem_we) begin
                  bmem[mem_addr] = word_to_u32(mem_wdata);
                  log_q.push_back('{1'b1, mem_addr,
                                    word_to_u32(mem_wdata)});
               end else begin
                  mem_rdata = u32_to_word(bmem_rd(mem_addr));
                  log_q.push_back('{1'b0, mem_addr,
                                    bmem_rd(mem_addr)});
               end
               mem_ack = 1'b1;
               lat     = $urandom_range(0, 3);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_b    = 1'b1;
      core_req = 1'b0;
      halted   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      model_reset();
      log_q.delete();
   endtask

   task automatic access(input bit we,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         output word_t rd);
      logic [31:0] a;
      logic [7:0]  idx;
      logic [21:0] tag;
      bit          hit;
      int          exp_lat;
      int          cyc;
      bit          got;
      logic [31:0] exp_rd;
      tx_t         exp_q[$];
      a   = addr & 32'hFFFF_FFFC;
      idx = a[9:2];
      tag = a[31:10];
      hit = rv[idx] && rt[idx] == tag;
      exp_rd  = exp_load(a);
      exp_lat = -1;
      if (hit) begin
         exp_lat = 0;
      end else begin
         if (rv[idx] && rdy[idx])
            exp_q.push_back('{1'b1, {rt[idx], idx, 2'b00}, rdat[idx]});
         if (!we)
            exp_q.push_back('{1'b0, a, 32'h0});
         if (we && exp_q.size() == 0)
            exp_lat = 1;
      end
      log_q.delete();
      @(negedge clk);
      core_req   = 1'b1;
      core_we    = we;
      core_addr  = addr;
      core_wdata = u32_to_word(wd);
      cyc = 0;
      got = 1'b0;
      rd  = '0;
      for (int c = 0; c < 400; c++) begin
         #1;
         if (core_ready) begin
            got = 1'b1;
            rd  = core_rdata;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      check("ready_seen", 32'(got), 32'd1);
      if (got)
         @(posedge clk);
      #1;
      core_req = 1'b0;
      if (exp_lat >= 0)
         check("latency", cyc, exp_lat);
      if (!we)
         check("rdata", word_to_u32(rd), exp_rd);
      check("tx_count", log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         check("tx_we", 32'(log_q[i].we), 32'(exp_q[i].we));
         check("tx_addr", log_q[i].addr, exp_q[i].addr);
         if (exp_q[i].we)
            check("tx_wdata", log_q[i].data, exp_q[i].data);
      end
      if (!hit) begin
         rv[idx]  = 1'b1;
         rt[idx]  = tag;
         rdy[idx] = 1'b0;
         if (!we)
            rdat[idx] = exp_rd;
      end
      if (we) begin
         rdat[idx] = wd;
         rdy[idx]  = 1'b1;
         arch[a]   = wd;
      end
   endtask

   task automatic flush_check(input bit with_req);
      tx_t exp_q[$];
      bit  seen_ready;
      bit  done;
      for (int i = 0; i < NL; i++)
         if (rv[i] && rdy[i])
            exp_q.push_back('{1'b1, {rt[i], 8'(i), 2'b00}, rdat[i]});
      log_q.delete();
      @(negedge clk);
      halted = 1'b1;
      if (with_req) begin
         core_req  = 1'b1;
         core_we   = 1'b0;
         core_addr = 32'h0000_7000;
      end
      seen_ready = 1'b0;
      done       = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         #1;
         if (core_ready)
            seen_ready = 1'b1;
         if (flush_done) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("flush_done", 32'(done), 32'd1);
      check("flush_ready", 32'(seen_ready), 32'd0);
      check("flush_cnt", log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         check("flush_we", 32'(log_q[i].we), 32'd1);
         check("flush_addr", log_q[i].addr, exp_q[i].addr);
         check("flush_data", log_q[i].data, exp_q[i].data);
      end
      repeat (5) @(negedge clk);
      #1;
      check("flush_sticky", 32'(flush_done), 32'd1);
      check("flush_ready_done", 32'(core_ready), 32'd0);
      check("flush_no_req", 32'(mem_req), 32'd0);
      core_req = 1'b0;
      foreach (arch[k])
         check("flush_mem", bmem_rd(k), arch[k]);
   endtask

   initial begin
      word_t       rd;
      logic [31:0] ra;
      bit          got;
      int          cyc;
      rst_b      = 1'b1;
      core_req   = 1'b0;
      core_we    = 1'b0;
      core_addr  = '0;
      core_wdata = '0;
      halted     = 1'b0;

      // reset values
      @(posedge clk);
      #1;
      check("rst_ready", 32'(core_ready), 32'd0);
      check("rst_rdata", word_to_u32(core_rdata), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", word_to_u32(mem_wdata), 32'd0);
      check("rst_flush_done", 32'(flush_done), 32'd0);
      do_reset();

      // cold load, then reload hit
      bmem[32'h100] = 32'hDEAD_BEEF;
      access(1'b0, 32'h100, 32'h0, rd);
      check("t1_b0", 32'(rd[0]), 32'h EF);
      check("t1_b1", 32'(rd[1]), 32'h BE);
      check("t1_b2", 32'(rd[2]), 32'h AD);
      check("t1_b3", 32'(rd[3]), 32'h DE);
      access(1'b0, 32'h100, 32'h0, rd);

      // store hit, then conflicting load evicts it
      access(1'b1, 32'h100, 32'h1122_3344, rd);
      access(1'b0, 32'h100 + 4 * NL, 32'h0, rd);

      // store miss to invalid line, then load hit
      access(1'b1, 32'h200, 32'hCAFE_0200, rd);
      access(1'b0, 32'h200, 32'h0, rd);

      // random traffic over a few conflicting indices
      for (int n = 0; n < 300; n++) begin
         int unsigned tg;
         int unsigned ix;
         tg = $urandom_range(0, 3);
         ix = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(0, 7);
         ra = (tg << 10) | (ix << 2) | $urandom_range(0, 3);
         access(1'(($urandom & 1)), ra, $urandom, rd);
      end
      flush_check(1'b0);

      // reset while a fill waits for its ack
      do_reset();
      mem_hold = 1'b1;
      @(negedge clk);
      core_req  = 1'b1;
      core_we   = 1'b0;
      core_addr = 32'h300;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_req) begin
            got = 1'b1;
            break;
         end
      end
      check("t5_req", 32'(got), 32'd1);
      check("t5_addr", mem_addr, 32'h300);
      @(negedge clk);
      rst_b    = 1'b1;
      core_req = 1'b0;
      @(posedge clk);
      #1;
      check("t5_rst_mreq", 32'(mem_req), 32'd0);
      @(negedge clk);
      rst_b = 1'b0;
      model_reset();
      force_ack = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("t5_late_mreq", 32'(mem_req), 32'd0);
      check("t5_late_done", 32'(flush_done), 32'd0);
      mem_hold = 1'b0;
      lat      = 0;
      access(1'b0, 32'h300, 32'h0, rd);

      // clean flush scans every line once
      do_reset();
      log_q.delete();
      @(negedge clk);
      halted = 1'b1;
      cyc = 0;
      got = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         cyc++;
         if (flush_done) begin
            got = 1'b1;
            break;
         end
      end
      check("clean_flush_done", 32'(got), 32'd1);
      check("clean_flush_cycles", cyc, NL + 1);
      check("clean_flush_tx", log_q.size(), 0);

      // two dirty lines flushed in index order, halted with a request
      do_reset();
      access(1'b1, 32'h0000_0320, 32'hAAAA_0200, rd);
      access(1'b1, 32'h0000_040C, 32'hBBBB_0003, rd);
      access(1'b0, 32'h0000_0010, 32'h0, rd);
      flush_check(1'b1);

`ifdef DCACHE_PERF_EN
      do_reset();
      access(1'b0, 32'h40, 32'h0, rd);
      access(1'b1, 32'h40, 32'h5555_0040, rd);
      access(1'b0, 32'h40 + 4 * NL, 32'h0, rd);
      check("perf_hit", hit_count, 32'd3);
      check("perf_miss", miss_count, 32'd2);
      check("perf_wb", wb_count, 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
